// File: rtl/interboard_pkg.sv
// ---------------------------------------------------------------------------
// interboard_pkg
// Shared definitions for the 4-phase Request/Ack interboard link between the
// two game boards. Used by both the receiver (receive_all) and the sender.
//   - word width and per-field widths of a move frame
//   - field-order constants: the step at which each field arrives
//   - RST_WORD, the data value that marks the remote-reset pattern
//   - handshake state encodings shared with the sender
//   - frame_t, the packed move-frame record, and frame_put(), which writes
//     one received word into the field selected by the step counter
// ---------------------------------------------------------------------------
package interboard_pkg;

  localparam int DATA_W     = 6;
  localparam int MSG_TYPE_W = 4;
  localparam int BLOCK_X_W  = 5;
  localparam int BLOCK_Y_W  = 3;
  localparam int CARD_W     = 6;
  localparam int SEL_LEN_W  = 3;
  localparam int MOVE_DIR_W = 1;

  localparam int STEP_W = 3;

  // Order in which the sender transmits the fields of one move frame.
  localparam logic [STEP_W-1:0] STEP_MSG_TYPE = 3'd0;
  localparam logic [STEP_W-1:0] STEP_BLOCK_X  = 3'd1;
  localparam logic [STEP_W-1:0] STEP_BLOCK_Y  = 3'd2;
  localparam logic [STEP_W-1:0] STEP_CARD     = 3'd3;
  localparam logic [STEP_W-1:0] STEP_SEL_LEN  = 3'd4;
  localparam logic [STEP_W-1:0] STEP_MOVE_DIR = 3'd5;

  // Request held high with this data long enough means "reset the other board".
  localparam logic [DATA_W-1:0] RST_WORD = 6'h3F;

  typedef enum logic [1:0] {
    WAIT_REQ_UP   = 2'd0,
    WAIT_REQ_DOWN = 2'd1,
    ACK_DROP      = 2'd2
  } hs_state_e;

  typedef struct packed {
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [BLOCK_X_W-1:0]  block_x;
    logic [BLOCK_Y_W-1:0]  block_y;
    logic [CARD_W-1:0]     card;
    logic [SEL_LEN_W-1:0]  sel_len;
    logic [MOVE_DIR_W-1:0] move_dir;
  } frame_t;

  // Words wider than their field keep only the low bits.
  function automatic frame_t frame_put(input frame_t f,
                                       input logic [STEP_W-1:0] step,
                                       input logic [DATA_W-1:0] w);
    frame_t r;
    r = f;
    case (step)
      STEP_MSG_TYPE: r.msg_type = w[MSG_TYPE_W-1:0];
      STEP_BLOCK_X:  r.block_x  = w[BLOCK_X_W-1:0];
      STEP_BLOCK_Y:  r.block_y  = w[BLOCK_Y_W-1:0];
      STEP_CARD:     r.card     = w[CARD_W-1:0];
      STEP_SEL_LEN:  r.sel_len  = w[SEL_LEN_W-1:0];
      STEP_MOVE_DIR: r.move_dir = w[MOVE_DIR_W-1:0];
      default:       r = f;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/receive_all_if.sv
// ---------------------------------------------------------------------------
// receive_all_if
// The physical interboard link: one 6-bit data bus plus the Request/Ack pair
// of a 4-phase handshake.
//   Request          sender -> receiver, asynchronous to the receiver clock
//   interboard_data  sender -> receiver, asynchronous, stable while Request=1
//   Ack              receiver -> sender, registered
// Modports: master = sending board, slave = receiving board.
// ---------------------------------------------------------------------------
interface receive_all_if;
  import interboard_pkg::*;

  logic              Request;
  logic [DATA_W-1:0] interboard_data;
  logic              Ack;

  modport master (output Request, output interboard_data, input Ack);
  modport slave  (input Request, input interboard_data, output Ack);

endinterface

// File: rtl/receive_single.sv
// ---------------------------------------------------------------------------
// receive_single
// Word-level receiver for the interboard link: synchronises Request and data,
// runs the 4-phase handshake, hands each captured word to the frame layer and
// detects the remote-reset pattern.
// Parameters: SYNC_STAGES (synchroniser depth, >=2), RST_HOLD (qualifying
// cycles of Request=1 with RST_WORD that make a remote reset).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   link            slave side of the interboard link (drives Ack)
//   word_valid      one-cycle pulse: word holds a newly captured data word
//   word            synchronised data word
//   remote_fire     one-cycle pulse on the cycle the remote reset qualifies
//   interboard_rst  registered version of remote_fire
//   hs_idle         FSM in WAIT_REQ_UP (only with RECEIVE_WATCHDOG_EN)
// ---------------------------------------------------------------------------
module receive_single
  import interboard_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 6
) (
  input  logic              clk,
  input  logic              rst,
  receive_all_if.slave      link,
  output logic              word_valid,
  output logic [DATA_W-1:0] word,
  output logic              remote_fire,
  output logic              interboard_rst
`ifdef RECEIVE_WATCHDOG_EN
  ,
  output logic              hs_idle
`endif
);

  localparam int CNT_W = $clog2(RST_HOLD + 1);

  // Request travels in the same chain as the data so both are seen together.
  logic [DATA_W:0] sync_q [SYNC_STAGES];
  logic [DATA_W:0] sync_d [SYNC_STAGES];

  logic              req_s;
  logic [DATA_W-1:0] data_s;
  logic              qual;

  hs_state_e        state_q, state_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             rst_pulse_q, rst_pulse_d;

  always_comb begin
    sync_d[0] = {link.Request, link.interboard_data};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign req_s  = sync_q[SYNC_STAGES-1][DATA_W];
  assign data_s = sync_q[SYNC_STAGES-1][DATA_W-1:0];
  assign qual   = req_s && (data_s == RST_WORD);

  // Remote-reset detection runs alongside the handshake. Once it fires, the
  // lock keeps it quiet until Request has dropped, and the FSM is parked in
  // WAIT_REQ_DOWN so Ack stays high for the whole reset request. A word that
  // would be captured in the firing cycle is dropped.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    lock_d      = lock_q;
    remote_fire = 1'b0;
    rst_pulse_d = 1'b0;
    word_valid  = 1'b0;

    if (qual && !lock_q) begin
      if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
        remote_fire = 1'b1;
        rst_pulse_d = 1'b1;
        lock_d      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!req_s) begin
      lock_d = 1'b0;
    end

    case (state_q)
      WAIT_REQ_UP: begin
        if (req_s) begin
          state_d    = WAIT_REQ_DOWN;
          word_valid = 1'b1;
        end
      end
      WAIT_REQ_DOWN: begin
        if (!req_s) begin
          state_d = ACK_DROP;
        end
      end
      ACK_DROP: begin
        state_d = WAIT_REQ_UP;
      end
      default: begin
        state_d = WAIT_REQ_UP;
      end
    endcase

    if (remote_fire) begin
      state_d    = WAIT_REQ_DOWN;
      word_valid = 1'b0;
    end

    ack_d = (state_d == WAIT_REQ_DOWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q     <= WAIT_REQ_UP;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      rst_pulse_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      state_q     <= state_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      rst_pulse_q <= rst_pulse_d;
    end
  end

  assign link.Ack       = ack_q;
  assign word           = data_s;
  assign interboard_rst = rst_pulse_q;

`ifdef RECEIVE_WATCHDOG_EN
  assign hs_idle = (state_q == WAIT_REQ_UP);
`endif

endmodule

// File: rtl/receive_all.sv
// ---------------------------------------------------------------------------
// receive_all
// Interboard frame receiver. Collects six handshaked words (msg_type, block_x,
// block_y, card, sel_len, move_dir) into shadow registers and, on the sixth,
// publishes them to GameControl with a one-cycle interboard_en strobe. A
// remote reset detected on the link is forwarded as interboard_rst.
// Parameters: SYNC_STAGES, RST_HOLD, WDOG_CYCLES (watchdog build only).
// Optional feature: RECEIVE_WATCHDOG_EN - abandon a partial frame after
// WDOG_CYCLES idle cycles between words.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   link                      slave side of the interboard link
//   interboard_en             one-cycle pulse, new frame on the field outputs
//   interboard_msg_type ..    field outputs, held until the next full frame
//   interboard_move_dir
//   interboard_rst            one-cycle pulse, remote reset detected
// ---------------------------------------------------------------------------
module receive_all
  import interboard_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 6
`ifdef RECEIVE_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 1_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  receive_all_if.slave          link,
  output logic                  interboard_en,
  output logic [MSG_TYPE_W-1:0] interboard_msg_type,
  output logic [BLOCK_X_W-1:0]  interboard_block_x,
  output logic [BLOCK_Y_W-1:0]  interboard_block_y,
  output logic [CARD_W-1:0]     interboard_card,
  output logic [SEL_LEN_W-1:0]  interboard_sel_len,
  output logic [MOVE_DIR_W-1:0] interboard_move_dir,
  output logic                  interboard_rst
);

  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic              remote_fire;
  logic              wdog_expire;

  logic [STEP_W-1:0] step_q, step_d;
  frame_t            shadow_q, shadow_d;
  frame_t            fields_q, fields_d;
  frame_t            frame_next;
  logic              en_q, en_d;

`ifdef RECEIVE_WATCHDOG_EN
  logic hs_idle;
`endif

  receive_single #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_HOLD   (RST_HOLD)
  ) u_single (
    .clk           (clk),
    .rst           (rst),
    .link          (link),
    .word_valid    (word_valid),
    .word          (word),
    .remote_fire   (remote_fire),
    .interboard_rst(interboard_rst)
`ifdef RECEIVE_WATCHDOG_EN
    ,
    .hs_idle       (hs_idle)
`endif
  );

`ifdef RECEIVE_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counts idle cycles between words of a partly received frame; any
  // capture, an empty frame or an open handshake restarts it.
  always_comb begin
    wdog_d      = '0;
    wdog_expire = 1'b0;
    if (!word_valid && (step_q != '0) && hs_idle) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_expire = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // The last word of a frame goes straight to the outputs together with the
  // shadows, so fields and interboard_en appear in the same cycle. Remote
  // reset and watchdog expiry abandon the partial frame without touching the
  // published fields.
  always_comb begin
    step_d     = step_q;
    shadow_d   = shadow_q;
    fields_d   = fields_q;
    en_d       = 1'b0;
    frame_next = frame_put(shadow_q, step_q, word);

    if (word_valid) begin
      shadow_d = frame_next;
      if (step_q == STEP_MOVE_DIR) begin
        step_d   = '0;
        fields_d = frame_next;
        en_d     = 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end

    if (remote_fire || wdog_expire) begin
      step_d   = '0;
      shadow_d = '0;
      en_d     = 1'b0;
      fields_d = fields_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= '0;
      shadow_q <= '0;
      fields_q <= '0;
      en_q     <= 1'b0;
    end else begin
      step_q   <= step_d;
      shadow_q <= shadow_d;
      fields_q <= fields_d;
      en_q     <= en_d;
    end
  end

  assign interboard_en       = en_q;
  assign interboard_msg_type = fields_q.msg_type;
  assign interboard_block_x  = fields_q.block_x;
  assign interboard_block_y  = fields_q.block_y;
  assign interboard_card     = fields_q.card;
  assign interboard_sel_len  = fields_q.sel_len;
  assign interboard_move_dir = fields_q.move_dir;

endmodule

// File: tb/tb_receive_all.sv
// ---------------------------------------------------------------------------
// tb_receive_all
// Directed bench for receive_all: plays the sending board over the 4-phase
// link and compares the published frames, Ack behaviour and remote-reset
// pulses with hand-computed values. The watchdog scenario is compiled in
// only when RECEIVE_WATCHDOG_EN is defined.
// ---------------------------------------------------------------------------
module tb_receive_all;
  import interboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       interboard_en;
  logic [3:0] interboard_msg_type;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic [5:0] interboard_card;
  logic [2:0] interboard_sel_len;
  logic [0:0] interboard_move_dir;
  logic       interboard_rst;

  receive_all_if link();

  // 100 MHz clock
  always #5 clk = ~clk;

  receive_all #(
    .SYNC_STAGES(2),
    .RST_HOLD   (6)
`ifdef RECEIVE_WATCHDOG_EN
    ,
    .WDOG_CYCLES(50)
`endif
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .link               (link),
    .interboard_en      (interboard_en),
    .interboard_msg_type(interboard_msg_type),
    .interboard_block_x (interboard_block_x),
    .interboard_block_y (interboard_block_y),
    .interboard_card    (interboard_card),
    .interboard_sel_len (interboard_sel_len),
    .interboard_move_dir(interboard_move_dir),
    .interboard_rst     (interboard_rst)
  );

  int   checkCount = 0;
  int   errorCount = 0;
  int   enCount    = 0;
  int   ackPulses  = 0;
  int   irstCount  = 0;
  logic ackPrev    = 1'b0;
  int   capMsg = 0, capX = 0, capY = 0, capCard = 0, capSel = 0, capDir = 0;
  int   lastRise = 0, lastFall = 0;
  int   e0, a0, r0, waitN;

  // Monitor on the falling edge: counts strobes and Ack pulses and records
  // the fields present in the same cycle as interboard_en.
  always @(negedge clk) begin
    if (interboard_en === 1'b1) begin
      enCount++;
      capMsg  = int'(interboard_msg_type);
      capX    = int'(interboard_block_x);
      capY    = int'(interboard_block_y);
      capCard = int'(interboard_card);
      capSel  = int'(interboard_sel_len);
      capDir  = int'(interboard_move_dir);
    end
    if (interboard_rst === 1'b1) irstCount++;
    if (link.Ack === 1'b1 && ackPrev !== 1'b1) ackPulses++;
    ackPrev = link.Ack;
  end

  // Global time limit so the bench always ends.
  initial begin
    #400000;
    $display("[TB] FAIL timeout: observed still running, expected finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 4-phase word transfer, starting and ending on a falling edge.
  task automatic applyStimulus(input logic [5:0] w);
    int n;
    link.interboard_data = w;
    link.Request         = 1'b1;
    n = 0;
    while (link.Ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lastRise = n;
    checkOutput("ack_rise", 32'(link.Ack), 32'd1);
    link.Request = 1'b0;
    n = 0;
    while (link.Ack !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lastFall = n;
    checkOutput("ack_fall", 32'(link.Ack), 32'd0);
  endtask

  task automatic applyFrame(input logic [5:0] a, input logic [5:0] b,
                            input logic [5:0] c, input logic [5:0] d,
                            input logic [5:0] e, input logic [5:0] f);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
    applyStimulus(d);
    applyStimulus(e);
    applyStimulus(f);
  endtask

  task automatic checkFrame(input string tag, input int m, input int x, input int y,
                            input int c, input int s, input int d);
    checkOutput({tag, ".msg_type"}, 32'(capMsg), 32'(m));
    checkOutput({tag, ".block_x"},  32'(capX),   32'(x));
    checkOutput({tag, ".block_y"},  32'(capY),   32'(y));
    checkOutput({tag, ".card"},     32'(capCard), 32'(c));
    checkOutput({tag, ".sel_len"},  32'(capSel), 32'(s));
    checkOutput({tag, ".move_dir"}, 32'(capDir), 32'(d));
  endtask

  initial begin
    rst                  = 1'b1;
    link.Request         = 1'b0;
    link.interboard_data = '0;
    idle(3);

    // Reset state
    checkOutput("reset.ack",  32'(link.Ack), 32'd0);
    checkOutput("reset.en",   32'(interboard_en), 32'd0);
    checkOutput("reset.irst", 32'(interboard_rst), 32'd0);
    checkOutput("reset.fields", 32'({interboard_msg_type, interboard_block_x,
                interboard_block_y, interboard_card, interboard_sel_len,
                interboard_move_dir}), 32'd0);
    rst = 1'b0;
    idle(2);

    // Frame A: ordinary frame, latency of Ack against Request
    $display("[TB] frame A");
    e0 = enCount; a0 = ackPulses; r0 = irstCount;
    applyFrame(6'd3, 6'd17, 6'd5, 6'd42, 6'd3, 6'd1);
    idle(3);
    checkOutput("A.en_count",  32'(enCount - e0),   32'd1);
    checkOutput("A.ack_count", 32'(ackPulses - a0), 32'd6);
    checkOutput("A.irst",      32'(irstCount - r0), 32'd0);
    checkOutput("A.rise_lat",  32'(lastRise), 32'd3);
    checkOutput("A.fall_lat",  32'(lastFall), 32'd3);
    checkFrame("A", 3, 17, 5, 42, 3, 1);
    checkOutput("A.en_low", 32'(interboard_en), 32'd0);

    // Frame B: 6'h3F as card inside a normal handshake is plain data
    $display("[TB] frame B");
    e0 = enCount; r0 = irstCount;
    applyFrame(6'd1, 6'd2, 6'd3, 6'h3F, 6'd4, 6'd0);
    idle(3);
    checkOutput("B.en_count", 32'(enCount - e0),   32'd1);
    checkOutput("B.irst",     32'(irstCount - r0), 32'd0);
    checkFrame("B", 1, 2, 3, 63, 4, 0);

    // Remote reset mid-frame: two words, then Request held with 6'h3F
    $display("[TB] remote reset");
    e0 = enCount; r0 = irstCount;
    applyStimulus(6'd7);
    applyStimulus(6'd9);
    link.interboard_data = 6'h3F;
    link.Request         = 1'b1;
    idle(12);
    checkOutput("rr.ack_held",   32'(link.Ack), 32'd1);
    checkOutput("rr.irst_count", 32'(irstCount - r0), 32'd1);
    checkOutput("rr.no_en",      32'(enCount - e0),   32'd0);
    checkOutput("rr.card_held",  32'(interboard_card), 32'd63);
    link.Request = 1'b0;
    waitN = 0;
    while (link.Ack !== 1'b0 && waitN < 40) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("rr.ack_release", 32'(link.Ack), 32'd0);
    idle(2);
    applyFrame(6'd9, 6'd30, 6'd6, 6'd7, 6'd2, 6'd1);
    idle(3);
    checkOutput("C.en_count",   32'(enCount - e0),   32'd1);
    checkOutput("C.irst_total", 32'(irstCount - r0), 32'd1);
    checkFrame("C", 9, 30, 6, 7, 2, 1);

    // Local reset after the third word, while Ack is high
    $display("[TB] local reset");
    applyStimulus(6'd5);
    applyStimulus(6'd6);
    applyStimulus(6'd7);
    link.interboard_data = 6'd11;
    link.Request         = 1'b1;
    waitN = 0;
    while (link.Ack !== 1'b1 && waitN < 40) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("lr.ack_before", 32'(link.Ack), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("lr.ack_async", 32'(link.Ack), 32'd0);
    checkOutput("lr.en",        32'(interboard_en), 32'd0);
    checkOutput("lr.fields", 32'({interboard_msg_type, interboard_block_x,
                interboard_block_y, interboard_card, interboard_sel_len,
                interboard_move_dir}), 32'd0);
    link.Request = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);
    e0 = enCount;
    applyFrame(6'd2, 6'd4, 6'd6, 6'd8, 6'd1, 6'd0);
    idle(3);
    checkOutput("D.en_count", 32'(enCount - e0), 32'd1);
    checkFrame("D", 2, 4, 6, 8, 1, 0);

    // Every word 6'h3F: narrower fields keep their low bits
    $display("[TB] truncation");
    e0 = enCount; r0 = irstCount;
    applyFrame(6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
    idle(3);
    checkOutput("E.en_count", 32'(enCount - e0),   32'd1);
    checkOutput("E.irst",     32'(irstCount - r0), 32'd0);
    checkFrame("E", 15, 31, 7, 63, 7, 1);

`ifdef RECEIVE_WATCHDOG_EN
    // Watchdog: two words, a long pause, then a complete frame
    $display("[TB] watchdog");
    e0 = enCount;
    applyStimulus(6'd1);
    applyStimulus(6'd2);
    idle(60);
    checkOutput("wd.no_en_idle", 32'(enCount - e0), 32'd0);
    applyFrame(6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd0);
    idle(3);
    checkOutput("wd.en_count", 32'(enCount - e0), 32'd1);
    checkFrame("W", 3, 4, 5, 6, 7, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/receive_all.md
# receive_all

Interboard receiver for the 4-phase Request/Ack link between the two game boards. It accepts six 6-bit words per move frame, in the order msg_type, block_x, block_y, card, sel_len, move_dir, acknowledging each word. When the frame is complete it presents the fields to GameControl with a one-cycle strobe. It also recognises the remote-reset pattern (Request held high with data 6'h3F) and converts it into a local reset pulse.

## Interface
- SYNC_STAGES, 2: synchroniser depth for Request and interboard_data (≥2)
- RST_HOLD, 6: consecutive synchronised cycles of Request=1 with data=6'h3F that qualify as remote reset
- WDOG_CYCLES, 1_000_000: inter-word timeout (only with RECEIVE_WATCHDOG_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; asynchronous, active-high
- Request  in  1  from other board, asynchronous
- interboard_data  in  6  from other board, asynchronous
- Ack  out  1  to other board, registered
- interboard_en  out  1  one-cycle pulse, frame complete
- interboard_msg_type  out  4  held field
- interboard_block_x  out  5  held field
- interboard_block_y  out  3  held field
- interboard_card  out  6  held field
- interboard_sel_len  out  3  held field
- interboard_move_dir  out  1  held field
- interboard_rst  out  1  one-cycle pulse, remote reset detected

## Operation
- Request and all six data bits pass through the same SYNC_STAGES flop chain, giving req_s and data_s. Data is sampled only from data_s.
- The handshake FSM (receive_single) has three states:
  - WAIT_REQ_UP: Ack=0. On req_s=1, capture data_s, raise Ack and go to WAIT_REQ_DOWN.
  - WAIT_REQ_DOWN: Ack=1. On req_s=0, go to ACK_DROP.
  - ACK_DROP: Ack=0 for one cycle, then go to WAIT_REQ_UP.
- Each capture issues a word_valid pulse to the frame layer.
- The frame layer keeps a step counter 0..5.
  - On word_valid, the captured word is written to a shadow register for the current step, truncated to the field width (low bits kept).
  - At step 5 the counter wraps to 0, all shadows are copied to the outputs and interboard_en pulses.
- Outputs hold their last frame until the next complete frame. Partial frames never disturb them.
- Remote reset:
  - A counter increments while req_s=1 and data_s=6'h3F, and clears otherwise.
  - When it reaches RST_HOLD: interboard_rst pulses once, the step counter and shadows clear, and the handshake FSM stays in WAIT_REQ_DOWN (Ack held at 1) until req_s falls.
  - No further interboard_rst fires until req_s has been 0 for at least one cycle.
  - A word 6'h3F inside a normal, shorter handshake is ordinary data (e.g. card=63).
- Local rst (asynchronous) clears all state mid-frame:
  - FSM goes to WAIT_REQ_UP and the step counter to 0.
  - Synchronisers, shadows and output fields all go to 0.
  - Ack, interboard_en and interboard_rst go to 0.

## Timing
- Reset values: every output 0.
- Request rise on pin → Ack rise: SYNC_STAGES+1 cycles.
- Request fall on pin → Ack fall: SYNC_STAGES+1 cycles. ACK_DROP adds one idle cycle before the next capture.
- 6th capture cycle → interboard_en high on the next cycle. Fields are valid in the same cycle as interboard_en.
- interboard_rst is asserted on the cycle after the RST_HOLD-th qualifying cycle.
- If remote-reset qualification and word capture fall in the same cycle, reset wins and the word is discarded.
- Minimum frame duration: 6 × (2·SYNC_STAGES+3) cycles.

## Configuration
- RECEIVE_WATCHDOG_EN defined:
  - A counter runs while the step counter is non-zero and the FSM is in WAIT_REQ_UP; any capture clears it.
  - At WDOG_CYCLES the step counter and shadows clear silently, with no interboard_en.
- RECEIVE_WATCHDOG_EN undefined: no counter. A partial frame waits indefinitely.

## Structure
- Package interboard_pkg holds:
  - field widths and the field-order constants STEP_MSG_TYPE..STEP_MOVE_DIR;
  - RST_WORD = 6'h3F;
  - the handshake state encodings WAIT_REQ_UP / WAIT_REQ_DOWN / ACK_DROP, shared with the sender.
- Sub-module receive_single contains the synchroniser, the handshake FSM, capture and remote-reset detection. receive_all contains the step counter, shadows, outputs and watchdog.

## Test plan
- Full frame, with the Request model raising Request, waiting for Ack, dropping Request and waiting for Ack low. Words 4'h3, 5'd17, 3'd5, 6'd42, 3'd3, 1 → a single interboard_en pulse with fields 3/17/5/42/3/1, and exactly 6 Ack pulses.
- Word 6'h3F as card inside a normal handshake → frame completes with card=63 and no interboard_rst.
- Request held high with data 6'h3F for 12 cycles mid-frame → interboard_rst pulses once, Ack stays high until Request falls, and the next full frame is received correctly from step 0.
- Local rst asserted after the 3rd word → Ack=0 immediately (asynchronous), fields 0, and the next frame is received intact.
- Words driven to 6'h3F where fields are narrower (block_y) → output is the low-bit truncation, 3'd7.
- With RECEIVE_WATCHDOG_EN and WDOG_CYCLES=50: 2 words, then 60 idle cycles, then 6 words → exactly one interboard_en, carrying the last 6 words.
